mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Initiator side of the data-memory interface: accepts one load/store request at a time from the CPU datapath.
- Sequences byte-wide accesses into the byte-addressed, big-endian data memory.
- Returns a single-cycle response pulse carrying the assembled 16-bit word or the extended byte.
- Sits between the execute stage and the data memory; it is the only block that drives the memory address/strobe lines.

Parameters:
- MEM_BYTES, 128, number of addressable bytes; any access touching address >= MEM_BYTES faults.
- ALIGN_CHECK, 1, when 1, a word access at an odd address faults; when 0, it proceeds as two byte accesses.

Ports:
- Clock  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- ReqValid  input  1  request present.
- ReqReady  output  1  unit can accept a request this cycle.
- ReqWrite  input  1  1 = store, 0 = load.
- ReqByte  input  1  1 = byte access, 0 = word access.
- ReqSigned  input  1  byte load only: 1 = sign-extend, 0 = zero-extend.
- ReqAddress  input  16  byte address.
- ReqWriteData  input  16  store data; byte store uses [7:0].
- RespValid  output  1  one-cycle response pulse.
- RespData  output  16  load result; 0 for stores and faults.
- RespFault  output  1  valid with RespValid: range or alignment fault.
- MemAddress  output  16  byte address to memory.
- MemWriteData  output  8  byte to write.
- MemWrite  output  1  byte write strobe, sampled by memory on rising Clock.
- MemRead  output  1  byte read strobe.
- MemReadData  input  8  byte read data, valid exactly one cycle after its MemRead cycle.

Behaviour:
- Reset (async, any state):
  - State returns to IDLE.
  - ReqReady=1; RespValid, RespFault, MemWrite and MemRead are 0.
  - RespData, MemAddress and MemWriteData are 0.
  - An interrupted word store may leave only the high byte written. This is accepted and no rollback occurs.
- Handshake:
  - ReqReady=1 only in IDLE.
  - A request is accepted on a rising edge with ReqValid&&ReqReady; all Req* fields are registered at that edge.
  - No backpressure on the response side: RespValid is high for exactly one cycle.
- States: IDLE, ISSUE0, ISSUE1, DRAIN, RESP.
- Fault check at acceptance:
  - Compute end = ReqAddress + (ReqByte ? 0 : 1) in 17 bits, so there is no wrap at 0xFFFF.
  - Range fault if end >= MEM_BYTES.
  - Alignment fault if ALIGN_CHECK && !ReqByte && ReqAddress[0].
  - On fault: go directly to RESP with RespFault=1 and RespData=0. No memory strobe is issued.
- Word store, accepted at edge E0:
  - ISSUE0: MemWrite=1, MemAddress=A, MemWriteData=D[15:8].
  - ISSUE1: MemWrite=1, MemAddress=A+1, MemWriteData=D[7:0].
  - RESP: response.
  - RespValid appears in the 3rd cycle after E0.
- Byte store: ISSUE0 with MemWriteData=D[7:0], then RESP (2nd cycle).
- Word load:
  - ISSUE0: MemRead=1, MemAddress=A.
  - ISSUE1: MemRead=1, MemAddress=A+1; the high byte is captured from MemReadData at the end of the cycle.
  - DRAIN: strobes 0; the low byte is captured at the end of the cycle.
  - RESP: RespData={hi,lo} (big-endian), RespValid in the 4th cycle.
- Byte load:
  - Sequence ISSUE0, DRAIN, RESP (3rd cycle).
  - RespData = ReqSigned ? {{8{b[7]}},b} : {8'h00,b}.
- Transitions:
  - RESP always returns to IDLE.
  - A request held on ReqValid is accepted on the edge that ends the IDLE cycle, so back-to-back requests have one idle cycle between responses.
- Invariants:
  - MemWrite and MemRead are never high together.
  - Outside strobe cycles, MemAddress and MemWriteData are 0.
  - RespData is 0 whenever RespValid=0.

Decomposition:
- Shared package mem_access_pkg:
  - state enum (IDLE/ISSUE0/ISSUE1/DRAIN/RESP);
  - default MEM_BYTES=128;
  - response latency constants (word load 4, byte load 3, word store 3, byte store 2, fault 1).
- One natural sub-module: mem_access_check, combinational range/alignment fault detection, reusable by the instruction-fetch path.

Test Plan:
- Word store A=2, D=0x1234 -> ISSUE0 MemAddress=2, MemWriteData=0x12; ISSUE1 MemAddress=3, MemWriteData=0x34; RespValid=1 in cycle 3, RespFault=0, RespData=0; memory model holds mem[2]=0x12, mem[3]=0x34.
- Word load A=2 after the above -> MemRead in cycles 1 and 2; RespData=0x1234 with RespValid in cycle 4.
- Byte load A=5 with mem[5]=0x94 -> ReqSigned=1 gives RespData=0xFF94; ReqSigned=0 gives 0x0094; both at cycle 3.
- Faults with MEM_BYTES=128:
  - word at 127 -> RespFault=1 in cycle 1;
  - word at 0xFFFF -> RespFault=1;
  - ALIGN_CHECK=1, word at 5 -> RespFault=1;
  - no MemRead/MemWrite in any of these.
- Reset asserted in ISSUE1 of word store A=10, D=0xABCD (mem[10..11]=0x00) -> outputs 0 immediately, mem[10]=0xAB, mem[11]=0x00; ReqReady=1 after release; next request serviced normally.
- ReqValid held high with two queued word loads -> second accepted on the edge ending the IDLE cycle after RESP; RespValid pulses exactly once per request.

Source files
------------

// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared state type, sizing and latency constants for the data-memory access unit
package mem_access_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE0 = 3'd1,
    ST_ISSUE1 = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_RESP   = 3'd4
  } state_t;

  localparam int DEFAULT_MEM_BYTES = 128;

  // Cycles from the accepting edge to the RespValid cycle
  localparam int LAT_WORD_LOAD  = 4;
  localparam int LAT_BYTE_LOAD  = 3;
  localparam int LAT_WORD_STORE = 3;
  localparam int LAT_BYTE_STORE = 2;
  localparam int LAT_FAULT      = 1;

  // Widen a loaded byte to the response width
  function automatic logic [15:0] extend_byte(input logic [7:0] b, input logic sign_ext);
    return sign_ext ? {{8{b[7]}}, b} : {8'h00, b};
  endfunction

endpackage

// File: rtl/mem_access_check.sv
// rtl/mem_access_check.sv - combinational range and alignment fault detection for a memory access
module mem_access_check
  import mem_access_pkg::*;
#(
  parameter int MEM_BYTES   = DEFAULT_MEM_BYTES,
  parameter int ALIGN_CHECK = 1
) (
  input  logic [15:0] i_address,
  input  logic        i_byte,
  output logic        o_fault
);

  logic [16:0] w_end;

  // Last touched byte is computed in 17 bits so 0xFFFF+1 does not wrap back into range
  always_comb begin
    w_end   = {1'b0, i_address} + {16'h0000, ~i_byte};
    o_fault = (w_end >= 17'(MEM_BYTES))
            || ((ALIGN_CHECK != 0) && !i_byte && i_address[0]);
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - sequences byte-wide big-endian data-memory accesses for one load/store at a time
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int MEM_BYTES   = DEFAULT_MEM_BYTES,
  parameter int ALIGN_CHECK = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_write,
  input  logic        i_req_byte,
  input  logic        i_req_signed,
  input  logic [15:0] i_req_address,
  input  logic [15:0] i_req_write_data,
  output logic        o_resp_valid,
  output logic [15:0] o_resp_data,
  output logic        o_resp_fault,
  output logic [15:0] o_mem_address,
  output logic [7:0]  o_mem_write_data,
  output logic        o_mem_write,
  output logic        o_mem_read,
  input  logic [7:0]  i_mem_read_data
);

  state_t      r_state;
  state_t      w_next;
  logic        w_fault;
  logic        w_accept;
  logic [15:0] r_addr;
  logic [15:0] r_wdata;
  logic        r_write;
  logic        r_byte;
  logic        r_signed;
  logic        r_fault;
  logic [7:0]  r_hi;
  logic [7:0]  r_lo;

  mem_access_check #(
    .MEM_BYTES  (MEM_BYTES),
    .ALIGN_CHECK(ALIGN_CHECK)
  ) u_check (
    .i_address(i_req_address),
    .i_byte   (i_req_byte),
    .o_fault  (w_fault)
  );

  assign w_accept = (r_state == ST_IDLE) && i_req_valid;

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Request capture at acceptance and read-data capture one cycle after each read strobe
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_addr   <= 16'h0000;
      r_wdata  <= 16'h0000;
      r_write  <= 1'b0;
      r_byte   <= 1'b0;
      r_signed <= 1'b0;
      r_fault  <= 1'b0;
      r_hi     <= 8'h00;
      r_lo     <= 8'h00;
    end else begin
      if (w_accept) begin
        r_addr   <= i_req_address;
        r_wdata  <= i_req_write_data;
        r_write  <= i_req_write;
        r_byte   <= i_req_byte;
        r_signed <= i_req_signed;
        r_fault  <= w_fault;
      end
      if (r_state == ST_ISSUE1 && !r_write) r_hi <= i_mem_read_data;
      if (r_state == ST_DRAIN)              r_lo <= i_mem_read_data;
    end
  end

  // Next state and all outputs; strobes and address lines stay 0 outside issue cycles
  always_comb begin
    w_next           = r_state;
    o_req_ready      = 1'b0;
    o_resp_valid     = 1'b0;
    o_resp_data      = 16'h0000;
    o_resp_fault     = 1'b0;
    o_mem_address    = 16'h0000;
    o_mem_write_data = 8'h00;
    o_mem_write      = 1'b0;
    o_mem_read       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) w_next = w_fault ? ST_RESP : ST_ISSUE0;
      end
      ST_ISSUE0: begin
        o_mem_address = r_addr;
        if (r_write) begin
          o_mem_write      = 1'b1;
          o_mem_write_data = r_byte ? r_wdata[7:0] : r_wdata[15:8];
          w_next           = r_byte ? ST_RESP : ST_ISSUE1;
        end else begin
          o_mem_read = 1'b1;
          w_next     = r_byte ? ST_DRAIN : ST_ISSUE1;
        end
      end
      ST_ISSUE1: begin
        o_mem_address = r_addr + 16'd1;
        if (r_write) begin
          o_mem_write      = 1'b1;
          o_mem_write_data = r_wdata[7:0];
          w_next           = ST_RESP;
        end else begin
          o_mem_read = 1'b1;
          w_next     = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        w_next = ST_RESP;
      end
      ST_RESP: begin
        o_resp_valid = 1'b1;
        o_resp_fault = r_fault;
        if (!r_fault && !r_write)
          o_resp_data = r_byte ? extend_byte(r_lo, r_signed) : {r_hi, r_lo};
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - self-checking bench for mem_access_unit with a byte memory and reference model
module tb_mem_access_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic        req_byte;
  logic        req_signed;
  logic [15:0] req_address;
  logic [15:0] req_write_data;
  logic        resp_valid;
  logic [15:0] resp_data;
  logic        resp_fault;
  logic [15:0] mem_address;
  logic [7:0]  mem_write_data;
  logic        mem_write;
  logic        mem_read;
  logic [7:0]  mem_read_data;

  int n_tests;
  int n_fail;

  logic [7:0] mem     [0:127];
  logic [7:0] ref_mem [0:127];
  logic       mem_clear;

  mem_access_unit #(.MEM_BYTES(128), .ALIGN_CHECK(1)) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_req_valid     (req_valid),
    .o_req_ready     (req_ready),
    .i_req_write     (req_write),
    .i_req_byte      (req_byte),
    .i_req_signed    (req_signed),
    .i_req_address   (req_address),
    .i_req_write_data(req_write_data),
    .o_resp_valid    (resp_valid),
    .o_resp_data     (resp_data),
    .o_resp_fault    (resp_fault),
    .o_mem_address   (mem_address),
    .o_mem_write_data(mem_write_data),
    .o_mem_write     (mem_write),
    .o_mem_read      (mem_read),
    .i_mem_read_data (mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte memory: writes sampled on the rising edge, read data registered one cycle after the strobe
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 128; i++) mem[i] <= 8'h00;
    end else if (mem_write && mem_address < 16'd128) begin
      mem[mem_address[6:0]] <= mem_write_data;
    end
    if (mem_read && mem_address < 16'd128) mem_read_data <= mem[mem_address[6:0]];
    else                                    mem_read_data <= 8'h00;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One request through the unit, checked against the architectural rules
  task automatic do_req(input logic wr, input logic byt, input logic sgn,
                        input logic [15:0] a, input logic [15:0] d, input string tag,
                        output logic [15:0] got_data, output logic got_fault, output int got_lat);
    int         end_a, exp_lat, exp_wr, exp_rd, cyc, nwr, nrd, nstb, inv, str_err;
    logic       fault;
    logic [7:0] b, exp_b;
    logic [15:0] exp_data;
    end_a = int'(a) + (byt ? 0 : 1);
    fault = (end_a >= 128) || (!byt && a[0]);
    if (fault)    exp_lat = 1;
    else if (wr)  exp_lat = byt ? 2 : 3;
    else          exp_lat = byt ? 3 : 4;
    exp_wr = (!fault && wr)  ? (byt ? 1 : 2) : 0;
    exp_rd = (!fault && !wr) ? (byt ? 1 : 2) : 0;
    exp_data = 16'h0000;
    if (!fault && !wr) begin
      if (byt) begin
        b = ref_mem[a[6:0]];
        exp_data = (sgn && b >= 8'd128) ? (16'hFF00 | 16'(b)) : 16'(b);
      end else begin
        exp_data = 16'(ref_mem[a[6:0]]) * 256 + 16'(ref_mem[a[6:0] + 7'd1]);
      end
    end

    @(negedge clk);
    for (int k = 0; k < 20 && !req_ready; k++) @(negedge clk);
    req_write = wr; req_byte = byt; req_signed = sgn;
    req_address = a; req_write_data = d; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 1; got_lat = 0; nwr = 0; nrd = 0; nstb = 0; inv = 0; str_err = 0;
    got_data = 16'hxxxx; got_fault = 1'bx;
    for (int k = 0; k < 12 && got_lat == 0; k++) begin
      if (mem_write && mem_read) inv++;
      if (!mem_write && !mem_read && (mem_address != 16'h0 || mem_write_data != 8'h0)) inv++;
      if (!resp_valid && resp_data != 16'h0) inv++;
      if (mem_write || mem_read) begin
        if (cyc != nstb + 1) str_err++;
        if (mem_address !== a + 16'(nstb)) str_err++;
        if (mem_write) begin
          exp_b = byt ? d[7:0] : (nstb == 0 ? d[15:8] : d[7:0]);
          if (mem_write_data !== exp_b) str_err++;
          nwr++;
        end else begin
          nrd++;
        end
        nstb++;
      end
      if (resp_valid) begin
        got_lat = cyc; got_data = resp_data; got_fault = resp_fault;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    check({tag, "_lat"},    got_lat,   exp_lat);
    check({tag, "_fault"},  got_fault, fault);
    check({tag, "_data"},   got_data,  exp_data);
    check({tag, "_nwr"},    nwr,       exp_wr);
    check({tag, "_nrd"},    nrd,       exp_rd);
    check({tag, "_strobe"}, str_err,   0);
    check({tag, "_inv"},    inv,       0);
    @(negedge clk);
    check({tag, "_pulse"},  resp_valid, 1'b0);
    check({tag, "_ready"},  req_ready,  1'b1);
    if (!fault && wr) begin
      if (byt) ref_mem[a[6:0]] = d[7:0];
      else begin
        ref_mem[a[6:0]]        = d[15:8];
        ref_mem[a[6:0] + 7'd1] = d[7:0];
      end
      check({tag, "_mem"}, mem[a[6:0]], ref_mem[a[6:0]]);
    end
  endtask

  initial begin
    logic [15:0] gd;
    logic        gf;
    int          gl, n_resp, c1, c2, mism;
    logic [15:0] d1, d2;
    logic        wr, byt, sgn;
    logic [15:0] a, d;
    int          r;

    n_tests = 0; n_fail = 0;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_byte = 1'b0; req_signed = 1'b0;
    req_address = 16'h0; req_write_data = 16'h0; mem_clear = 1'b1;
    for (int i = 0; i < 128; i++) ref_mem[i] = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_ready",  req_ready,      1'b1);
    check("rst_rvalid", resp_valid,     1'b0);
    check("rst_rfault", resp_fault,     1'b0);
    check("rst_rdata",  resp_data,      16'h0);
    check("rst_mwr",    mem_write,      1'b0);
    check("rst_mrd",    mem_read,       1'b0);
    check("rst_maddr",  mem_address,    16'h0);
    check("rst_mwdata", mem_write_data, 8'h0);
    rst = 1'b0; mem_clear = 1'b0;

    do_req(1'b1, 1'b0, 1'b0, 16'd2, 16'h1234, "wst2", gd, gf, gl);
    check("wst2_mem2", mem[2], 8'h12);
    check("wst2_mem3", mem[3], 8'h34);
    do_req(1'b0, 1'b0, 1'b0, 16'd2, 16'h0, "wld2", gd, gf, gl);
    check("wld2_val", gd, 16'h1234);
    check("wld2_cyc", gl, 4);
    do_req(1'b1, 1'b1, 1'b0, 16'd5, 16'h0094, "bst5", gd, gf, gl);
    do_req(1'b0, 1'b1, 1'b1, 16'd5, 16'h0, "bld5s", gd, gf, gl);
    check("bld5s_val", gd, 16'hFF94);
    do_req(1'b0, 1'b1, 1'b0, 16'd5, 16'h0, "bld5u", gd, gf, gl);
    check("bld5u_val", gd, 16'h0094);
    check("bld5u_cyc", gl, 3);
    do_req(1'b0, 1'b0, 1'b0, 16'd127,   16'h0, "f127",  gd, gf, gl);
    check("f127_fault", gf, 1'b1);
    do_req(1'b1, 1'b0, 1'b0, 16'hFFFF,  16'h5555, "fffff", gd, gf, gl);
    check("fffff_fault", gf, 1'b1);
    do_req(1'b0, 1'b0, 1'b0, 16'd5,     16'h0, "fodd",  gd, gf, gl);
    check("fodd_fault", gf, 1'b1);
    do_req(1'b0, 1'b1, 1'b0, 16'd127,   16'h0, "b127",  gd, gf, gl);
    check("b127_ok", gf, 1'b0);
    do_req(1'b1, 1'b1, 1'b0, 16'd128,   16'h0011, "b128", gd, gf, gl);
    check("b128_fault", gf, 1'b1);

    // Reset during the second write of a word store
    @(negedge clk);
    req_write = 1'b1; req_byte = 1'b0; req_signed = 1'b0;
    req_address = 16'd10; req_write_data = 16'hABCD; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    check("rstw_i0_wr",   mem_write,   1'b1);
    check("rstw_i0_addr", mem_address, 16'd10);
    @(negedge clk);
    check("rstw_i1_addr", mem_address, 16'd11);
    rst = 1'b1;
    #1;
    check("rstw_mwr",   mem_write,      1'b0);
    check("rstw_maddr", mem_address,    16'h0);
    check("rstw_mwd",   mem_write_data, 8'h0);
    check("rstw_rv",    resp_valid,     1'b0);
    check("rstw_ready", req_ready,      1'b1);
    @(negedge clk);
    rst = 1'b0;
    check("rstw_mem10", mem[10], 8'hAB);
    check("rstw_mem11", mem[11], 8'h00);
    ref_mem[10] = 8'hAB;
    @(negedge clk);
    check("rstw_ready2", req_ready, 1'b1);
    do_req(1'b0, 1'b0, 1'b0, 16'd10, 16'h0, "wld10", gd, gf, gl);
    check("wld10_val", gd, 16'hAB00);

    // Two word loads with ReqValid held
    @(negedge clk);
    req_write = 1'b0; req_byte = 1'b0; req_address = 16'd2; req_valid = 1'b1;
    @(negedge clk);
    req_address = 16'd10;
    n_resp = 0; c1 = 0; c2 = 0; d1 = 16'h0; d2 = 16'h0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      if (cyc == 6) req_valid = 1'b0;
      if (resp_valid) begin
        n_resp++;
        if (n_resp == 1) begin c1 = cyc; d1 = resp_data; end
        else             begin c2 = cyc; d2 = resp_data; end
      end
      @(negedge clk);
    end
    check("b2b_nresp", n_resp, 2);
    check("b2b_c1",    c1, 4);
    check("b2b_d1",    d1, 16'h1234);
    check("b2b_c2",    c2, 9);
    check("b2b_d2",    d2, 16'hAB00);

    // Randomized mix against the reference model
    for (int t = 0; t < 40; t++) begin
      wr = 1'($urandom_range(0, 1));
      byt = 1'($urandom_range(0, 1));
      sgn = 1'($urandom_range(0, 1));
      d = 16'($urandom);
      r = $urandom_range(0, 9);
      if (r == 0)      a = 16'($urandom);
      else if (r == 1) a = 16'(126 + $urandom_range(0, 3));
      else             a = 16'($urandom_range(0, 127));
      do_req(wr, byt, sgn, a, d, $sformatf("rnd%0d", t), gd, gf, gl);
    end

    mism = 0;
    for (int i = 0; i < 128; i++) if (mem[i] !== ref_mem[i]) mism++;
    check("final_mem", mism, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
